// File: rtl/mult_8x8_seq_sched.sv
// 8x8 multiply scheduled over one shared 4x4 unit, one nibble pair per cycle.
// Partials combine by shift-add or shift-OR; zero operands may skip the unit.
module mult_8x8_seq_sched #(
  parameter int COMBINE_MODE = 0,
  parameter int SKIP_ZERO    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_idx,
  input  logic [7:0]  mul_p,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
  logic [15:0] part;
  logic [15:0] acc_nxt;
  logic [1:0]  idx_n;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic        zero_op;

  always_comb begin
    part = '0;
    unique case (1'b1)
      (mul_idx == 2'd0): part = {8'h00, mul_p};
      (mul_idx == 2'd3): part = {mul_p, 8'h00};
      default:           part = {4'h0, mul_p, 4'h0};
    endcase
  end

  assign acc_nxt = (COMBINE_MODE != 0) ? (acc | part)
                                       : (acc + part);

  // Order: lo*lo, lo*hi, hi*lo, hi*hi
  assign idx_n = mul_idx + 2'd1;
  assign nib_a = idx_n[1] ? a_q[7:4] : a_q[3:0];
  assign nib_b = idx_n[0] ? b_q[7:4] : b_q[3:0];

  assign zero_op = (SKIP_ZERO != 0) &&
                   ((A == 8'h00) || (B == 8'h00));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      R         <= '0;
      busy      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_idx   <= '0;
      op_count  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            acc      <= '0;
            mul_idx  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (zero_op) begin
              state <= DONE;
              R     <= '0;
            end else begin
              state <= CALC;
              mul_a <= A[3:0];
              mul_b <= B[3:0];
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (mul_idx == 2'd3) begin
            state     <= DONE;
            R         <= acc_nxt;
            out_valid <= 1'b1;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_idx   <= '0;
          end else begin
            mul_idx <= idx_n;
            mul_a   <= nib_a;
            mul_b   <= nib_b;
          end
        end
        DONE: begin
          // Skipped ops arrive with out_valid low; raise it one edge later
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
            op_count  <= op_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_sched.sv
// Bench for mult_8x8_seq_sched: three flavours (add/skip, or/skip, add/noskip)
// driven by directed and random ops against an arithmetic reference model.
module tb_mult_8x8_seq_sched;

  logic        clk;
  logic        rst;
  logic        in_valid [3];
  logic        in_ready [3];
  logic [7:0]  a_i      [3];
  logic [7:0]  b_i      [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [15:0] r        [3];
  logic        busy     [3];
  logic [3:0]  mul_a    [3];
  logic [3:0]  mul_b    [3];
  logic [1:0]  mul_idx  [3];
  logic [7:0]  mul_p    [3];
  logic [15:0] op_count [3];
  bit          force_ff [3];
  int          exp_cnt  [3];

  int checks;
  int failures;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mul_p[g] = force_ff[g] ? 8'hFF
                    : ({4'h0, mul_a[g]} * {4'h0, mul_b[g]});
    mult_8x8_seq_sched #(
      .COMBINE_MODE((g == 1) ? 1 : 0),
      .SKIP_ZERO   ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .A        (a_i[g]),
      .B        (b_i[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .R        (r[g]),
      .busy     (busy[g]),
      .mul_a    (mul_a[g]),
      .mul_b    (mul_b[g]),
      .mul_idx  (mul_idx[g]),
      .mul_p    (mul_p[g]),
      .op_count (op_count[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int d,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, d, obs, exp);
    end
  endtask

  // Product as the sum (or OR) of the four weighted nibble products
  function automatic logic [15:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input int d,
                                        input bit ff);
    int          sum;
    logic [31:0] orv;
    int          pa, pb, p, sh;
    if (d != 2 && (a == 0 || b == 0)) return 16'h0000;
    sum = 0;
    orv = 0;
    for (int i = 0; i < 4; i++) begin
      pa  = (i >= 2) ? int'(a[7:4]) : int'(a[3:0]);
      pb  = (i % 2 == 1) ? int'(b[7:4]) : int'(b[3:0]);
      p   = ff ? 255 : pa * pb;
      sh  = 4 * ((i >= 2 ? 1 : 0) + (i % 2));
      sum = sum + (p << sh);
      orv = orv | 32'(p << sh);
    end
    return (d == 1) ? orv[15:0] : sum[15:0];
  endfunction

  task automatic do_op(input int d, input logic [7:0] a,
                       input logic [7:0] b, input int hold);
    int          lat;
    bit          skip;
    logic [15:0] exp;
    logic [3:0]  ea, eb;
    skip = (d != 2) && (a == 0 || b == 0);
    exp  = model(a, b, d, force_ff[d]);
    lat  = 0;
    while (!in_ready[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("in_ready_idle", d, 32'(in_ready[d]), 1);
    a_i[d]       = a;
    b_i[d]       = b;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b0;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a_i[d]      = 8'($urandom);
    b_i[d]      = 8'($urandom);
    check("busy", d, 32'(busy[d]), 1);
    check("in_ready_busy", d, 32'(in_ready[d]), 0);
    lat = 0;
    while (!out_valid[d] && lat < 12) begin
      if (skip) begin
        check("skip_mul_ab", d, {mul_a[d], mul_b[d]}, 0);
      end else if (lat < 4) begin
        ea = (lat >= 2) ? a[7:4] : a[3:0];
        eb = (lat % 2 == 1) ? b[7:4] : b[3:0];
        check("mul_idx", d, 32'(mul_idx[d]), 32'(lat));
        check("mul_ab", d, {mul_a[d], mul_b[d]}, {ea, eb});
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", d, 32'(lat), skip ? 1 : 4);
    check("R", d, 32'(r[d]), 32'(exp));
    check("done_mul_ab", d, {mul_a[d], mul_b[d]}, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'b1;
      a_i[d]      = 8'($urandom);
      b_i[d]      = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid", d, 32'(out_valid[d]), 1);
      check("hold_R", d, 32'(r[d]), 32'(exp));
      check("hold_in_ready", d, 32'(in_ready[d]), 0);
      check("hold_count", d, 32'(op_count[d]), 32'(exp_cnt[d]));
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    exp_cnt[d]   = (exp_cnt[d] + 1) & 16'hFFFF;
    check("release_valid", d, 32'(out_valid[d]), 0);
    check("op_count", d, 32'(op_count[d]), 32'(exp_cnt[d]));
    check("release_busy", d, 32'(busy[d]), 0);
    check("R_kept", d, 32'(r[d]), 32'(exp));
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         rd;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      a_i[d]       = 8'h00;
      b_i[d]       = 8'h00;
      force_ff[d]  = 1'b0;
      exp_cnt[d]   = 0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", d, 32'(in_ready[d]), 0);
      check("rst_out_valid", d, 32'(out_valid[d]), 0);
      check("rst_R", d, 32'(r[d]), 0);
      check("rst_busy", d, 32'(busy[d]), 0);
      check("rst_mul", d, {mul_a[d], mul_b[d], 2'b00, mul_idx[d]}, 0);
      check("rst_count", d, 32'(op_count[d]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++)
      check("idle_in_ready", d, 32'(in_ready[d]), 1);

    do_op(0, 8'hFF, 8'hFF, 0);
    check("ff_x_ff", 0, 32'(r[0]), 32'h0000FE01);
    check("ff_count", 0, 32'(op_count[0]), 1);
    do_op(0, 8'h12, 8'h34, 0);
    check("add_12_34", 0, 32'(r[0]), 32'h000003A8);
    do_op(1, 8'h12, 8'h34, 0);
    check("or_12_34", 1, 32'(r[1]), 32'h00000368);
    do_op(0, 8'h00, 8'hAB, 0);
    do_op(2, 8'h00, 8'hAB, 0);
    do_op(1, 8'h5C, 8'h00, 1);
    do_op(0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 3);

    force_ff[0] = 1'b1;
    do_op(0, 8'h11, 8'h11, 0);
    check("wrap_1fdf", 0, 32'(r[0]), 32'h00001FDF);
    force_ff[0] = 1'b0;

    for (int n = 0; n < 30; n++) begin
      rd = $urandom_range(0, 2);
      ra = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      force_ff[rd] = ($urandom_range(0, 7) == 0);
      do_op(rd, ra, rb, $urandom_range(0, 2));
      force_ff[rd] = 1'b0;
    end

    a_i[0]      = 8'h12;
    b_i[0]      = 8'h34;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_idx", 0, 32'(mul_idx[0]), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      exp_cnt[d] = 0;
      check("mid_rst_valid", d, 32'(out_valid[d]), 0);
      check("mid_rst_R", d, 32'(r[d]), 0);
      check("mid_rst_busy", d, 32'(busy[d]), 0);
      check("mid_rst_count", d, 32'(op_count[d]), 0);
    end
    check("mid_rst_mul", 0, {mul_a[0], mul_b[0], 2'b00, mul_idx[0]}, 0);
    do_op(0, 8'h03, 8'h05, 0);
    check("after_rst", 0, 32'(r[0]), 32'h0000000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_8x8_seq_sched.md
Name: mult_8x8_seq_sched

Overview:
Sequential scheduler that computes one 8x8 product by time-sharing a single external 4x4 multiplier unit over four cycles. The external unit may be exact or approximate. The block issues the four nibble-pair operands in a fixed order and accumulates the returned partial products. Combining is either exact shift-add or OR-compression. It sits between a valid/ready operand source and a valid/ready result sink, and replaces four parallel 4x4 instances where area matters.

Parameters:
COMBINE_MODE, 0, partial-product combine: 0 = shift-add (mod 2^16), 1 = shift-OR
SKIP_ZERO, 1, 1 = bypass the four multiply cycles when A==0 or B==0

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
A  input  8  multiplicand
B  input  8  multiplier
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
R  output  16  product
busy  output  1  high in any state except IDLE
mul_a  output  4  nibble to shared 4x4 unit
mul_b  output  4  nibble to shared 4x4 unit
mul_idx  output  2  partial index being issued (selects unit flavour externally)
mul_p  input  8  combinational product from shared unit, same cycle
op_count  output  16  completed-result counter

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. out_valid=0, R=0, busy=0, mul_a=0, mul_b=0, mul_idx=0, op_count=0. Operand regs and accumulator are cleared.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid & in_ready at an edge, latch A/B, clear acc and idx.
  - If SKIP_ZERO and (A==0 or B==0): go to DONE with acc=0.
  - Otherwise: go to CALC.
- CALC: idx counts 0..3, one per cycle. mul_a/mul_b/mul_idx are driven from the registered idx and operands:
  - idx0: A[3:0]×B[3:0], shift 0
  - idx1: A[3:0]×B[7:4], shift 4
  - idx2: A[7:4]×B[3:0], shift 4
  - idx3: A[7:4]×B[7:4], shift 8
  - At each edge, mul_p is zero-extended to 16 bits, shifted, and combined into acc: + (wrap mod 2^16) or | per COMBINE_MODE.
  - On the edge with idx==3, go to DONE.
- Latency: out_valid rises on the 4th edge after the accept edge (1st edge when zero-skipped).
- DONE: out_valid=1; R=acc, held stable while out_ready=0. On edge with out_ready=1: go to IDLE, op_count+=1 (wraps at 0xFFFF→0).
- Throughput: one result per 6 cycles best case. No overlap; in_ready=0 in CALC and DONE.
- mul_a/mul_b are 0 outside CALC. mul_p is ignored outside CALC (X-tolerant).
- R keeps its last value after leaving DONE until the next DONE; it is meaningful only with out_valid.
- rst asserted in any state (including mid-CALC or DONE with out_valid high) takes effect at the next edge. The in-flight op is discarded, outputs return to reset values, and op_count clears.
- in_valid with A/B changing while in_ready=0 has no effect.

Test Plan:
- Exact bench unit, mode 0: A=0xFF, B=0xFF → mul_idx 0,1,2,3 on consecutive cycles; out_valid 4 edges after accept; R=0xFE01; op_count=1.
- Exact bench unit, mode 0 then mode 1, A=0x12, B=0x34 → partials 0x08, 0x06, 0x04, 0x03; R=0x03A8 (mode 0), R=0x0368 (mode 1).
- SKIP_ZERO=1: A=0x00, B=0xAB → out_valid 1 edge after accept; R=0x0000; mul_a/mul_b stay 0. With SKIP_ZERO=0 → 4-cycle path, R=0x0000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → R and out_valid stable; in_ready=0; in_valid pulses ignored; op_count increments once on release.
- Overflow wrap, mode 0: bench unit forced to mul_p=0xFF for all partials → R=0x1FDF (73695 mod 65536).
- Reset mid-op: assert rst at idx==2 → next edge: state IDLE, out_valid=0, R=0, op_count=0. Next op A=0x03, B=0x05 → R=0x000F.
